// File: rtl/speed_gate_ctrl_pkg.sv
// Shared types and defaults for the speed/barrier sequencing controller.
package speed_gate_ctrl_pkg;

  // Speed is 14400/cycles, so a result never exceeds this constant.
  localparam int unsigned SPEED_CONST     = 14400;
  localparam int unsigned WIDTH_SPEED_DEF = $clog2(SPEED_CONST + 1);
  localparam int unsigned SPEED_LIMIT_DEF = 40;
  localparam int unsigned MAX_VEH_DEF     = 3;

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    WAIT_DONE,
    DECIDE,
    OPEN,
    REJECT
  } state_t;

  typedef struct packed {
    logic init;
    logic count;
    logic cal;
    logic up;
    logic down;
    logic en;
    logic dis;
  } cmd_t;

endpackage

// File: rtl/speed_gate_ctrl_edge_det.sv
// Rising-edge detector for an already-synchronized sensor input.
module speed_gate_ctrl_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/speed_gate_ctrl.sv
// Sequencing FSM: sensor edges in, single-cycle datapath commands out.
module speed_gate_ctrl
  import speed_gate_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_SPEED = WIDTH_SPEED_DEF,
  parameter int unsigned SPEED_LIMIT = SPEED_LIMIT_DEF,
  parameter int unsigned MAX_VEH     = MAX_VEH_DEF,
  parameter int unsigned TIMEOUT_CYC = 100000000,
  parameter int unsigned BARRIER_CYC = 150000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sen1,
  input  logic                   sen2,
  input  logic                   exit_sen,
  input  logic                   done,
  input  logic [WIDTH_SPEED-1:0] speed,
  input  logic [1:0]             num_veh,
  output logic                   init,
  output logic                   count,
  output logic                   cal,
  output logic                   up,
  output logic                   down,
  output logic                   en,
  output logic                   dis,
  output logic                   overspeed,
  output logic                   busy
);

  localparam logic [WIDTH_SPEED-1:0] LIMIT    = WIDTH_SPEED'(SPEED_LIMIT);
  localparam logic [1:0]             CAP      = 2'(MAX_VEH);
  localparam logic [31:0]            TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0]            BAR_LAST = 32'(BARRIER_CYC - 1);

  logic sen1_rise, sen2_rise, exit_rise;

  speed_gate_ctrl_edge_det u_sen1 (.clk(clk), .reset(reset), .d(sen1),     .rise(sen1_rise));
  speed_gate_ctrl_edge_det u_sen2 (.clk(clk), .reset(reset), .d(sen2),     .rise(sen2_rise));
  speed_gate_ctrl_edge_det u_exit (.clk(clk), .reset(reset), .d(exit_sen), .rise(exit_rise));

  state_t                 state, state_d;
  cmd_t                   cmd_q, cmd_d;
  logic                   busy_q, busy_d;
  logic                   ovs_q, ovs_d;
  logic                   exit_pend, exit_pend_d;
  logic                   entry_pend, entry_pend_d;
  logic [WIDTH_SPEED-1:0] spd_q, spd_d;
  logic [31:0]            tmr;

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d      = state;
    cmd_d        = '0;
    ovs_d        = ovs_q;
    exit_pend_d  = exit_pend;
    entry_pend_d = entry_pend;
    spd_d        = spd_q;

    unique case (state)
      IDLE: begin
        // Exit service wins so up and down can never coincide.
        if (exit_pend) begin
          exit_pend_d = 1'b0;
          cmd_d.down  = (num_veh != 2'd0);
        end else if (sen1_rise || entry_pend) begin
          entry_pend_d = 1'b0;
          cmd_d.init   = 1'b1;
          state_d      = MEASURE;
        end
      end
      MEASURE: begin
        if (sen2_rise) begin
          cmd_d.cal = 1'b1;
          state_d   = WAIT_DONE;
        end else if (tmr == TMO_LAST) begin
          cmd_d.dis = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          spd_d   = speed;
          state_d = DECIDE;
        end else if (tmr == TMO_LAST) begin
          cmd_d.dis = 1'b1;
          state_d   = IDLE;
        end
      end
      DECIDE: begin
        if (spd_q <= LIMIT && num_veh < CAP) begin
          cmd_d.up = 1'b1;
          state_d  = OPEN;
        end else begin
          cmd_d.dis = 1'b1;
          ovs_d     = (spd_q > LIMIT);
          state_d   = REJECT;
        end
      end
      OPEN: begin
        if (tmr == BAR_LAST) begin
          cmd_d.dis = 1'b1;
          ovs_d     = 1'b0;
          state_d   = IDLE;
        end
      end
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Level outputs follow the state they describe, one register stage later.
    cmd_d.count = (state_d == MEASURE);
    cmd_d.en    = (state_d == OPEN);
    busy_d      = (state_d != IDLE);

    if (exit_rise) exit_pend_d = 1'b1;
    if (sen1_rise && state != IDLE && state != MEASURE) entry_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd_q      <= '0;
      busy_q     <= 1'b0;
      ovs_q      <= 1'b0;
      exit_pend  <= 1'b0;
      entry_pend <= 1'b0;
      spd_q      <= '0;
      tmr        <= '0;
    end else begin
      state      <= state_d;
      cmd_q      <= cmd_d;
      busy_q     <= busy_d;
      ovs_q      <= ovs_d;
      exit_pend  <= exit_pend_d;
      entry_pend <= entry_pend_d;
      spd_q      <= spd_d;
      // One counter serves both timeout and barrier hold; it restarts on every state entry.
      tmr        <= (state_d != state) ? '0 : tmr + 32'd1;
    end
  end

  assign init      = cmd_q.init;
  assign count     = cmd_q.count;
  assign cal       = cmd_q.cal;
  assign up        = cmd_q.up;
  assign down      = cmd_q.down;
  assign en        = cmd_q.en;
  assign dis       = cmd_q.dis;
  assign overspeed = ovs_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_speed_gate_ctrl.sv
// Self-checking bench for speed_gate_ctrl with a pass-level behavioural model.
module tb_speed_gate_ctrl;

  localparam int B     = 8;
  localparam int TMO   = 200;
  localparam int TMO_T = 20;
  localparam int LIM   = 40;
  localparam int CAPV  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sen1 = 1'b0, sen2 = 1'b0, exit_sen = 1'b0, done = 1'b0;
  logic [13:0] speed = '0;
  logic [1:0]  num_veh = '0;

  logic init, count, cal, up, down, en, dis, overspeed, busy;
  logic t_init, t_count, t_cal, t_up, t_down, t_en, t_dis, t_overspeed, t_busy;
  logic [8:0] outs;
  assign outs = {init, count, cal, up, down, en, dis, overspeed, busy};

  always #5 clk = ~clk;

  speed_gate_ctrl #(.TIMEOUT_CYC(TMO), .BARRIER_CYC(B)) dut (
    .clk(clk), .reset(reset), .sen1(sen1), .sen2(sen2), .exit_sen(exit_sen),
    .done(done), .speed(speed), .num_veh(num_veh),
    .init(init), .count(count), .cal(cal), .up(up), .down(down), .en(en),
    .dis(dis), .overspeed(overspeed), .busy(busy)
  );

  // Second instance with a short timeout, used only for the timeout scenario.
  speed_gate_ctrl #(.TIMEOUT_CYC(TMO_T), .BARRIER_CYC(B)) dut_t (
    .clk(clk), .reset(reset), .sen1(sen1), .sen2(sen2), .exit_sen(exit_sen),
    .done(done), .speed(speed), .num_veh(num_veh),
    .init(t_init), .count(t_count), .cal(t_cal), .up(t_up), .down(t_down), .en(t_en),
    .dis(t_dis), .overspeed(t_overspeed), .busy(t_busy)
  );

  int checks = 0;
  int errors = 0;

  // Running totals sampled on the falling edge.
  int cyc = 0;
  int m_init = 0, m_count = 0, m_cal = 0, m_up = 0, m_down = 0, m_en = 0, m_dis = 0;
  int m_updown = 0, m_down_busy = 0, t_count_n = 0, t_dis_n = 0;
  int en_last = 0, dis_last = 0, down_last = 0, idle_first = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc         <= cyc + 1;
    m_init      <= m_init + (init ? 1 : 0);
    m_count     <= m_count + (count ? 1 : 0);
    m_cal       <= m_cal + (cal ? 1 : 0);
    m_up        <= m_up + (up ? 1 : 0);
    m_down      <= m_down + (down ? 1 : 0);
    m_en        <= m_en + (en ? 1 : 0);
    m_dis       <= m_dis + (dis ? 1 : 0);
    m_updown    <= m_updown + ((up && down) ? 1 : 0);
    m_down_busy <= m_down_busy + ((down && busy) ? 1 : 0);
    t_count_n   <= t_count_n + (t_count ? 1 : 0);
    t_dis_n     <= t_dis_n + (t_dis ? 1 : 0);
    if (en)   en_last   <= cyc;
    if (dis)  dis_last  <= cyc;
    if (down) down_last <= cyc;
    if (busy_prev && !busy) idle_first <= cyc;
    busy_prev <= busy;
  end

  int b_init, b_count, b_cal, b_up, b_down, b_en, b_dis, b_updown, b_down_busy, b_tcount, b_tdis;

  task automatic snap();
    b_init = m_init; b_count = m_count; b_cal = m_cal; b_up = m_up; b_down = m_down;
    b_en = m_en; b_dis = m_dis; b_updown = m_updown; b_down_busy = m_down_busy;
    b_tcount = t_count_n; b_tdis = t_dis_n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One vehicle pass: sen1 edge, sen2 edge gap cycles later, then a speed result.
  task automatic run_pass(input string tag, input int gap, input int spd, input int nv,
                          input bit exit_open);
    bit admit;
    int exp_ovs;
    int k;
    admit   = (spd <= LIM) && (nv < CAPV);
    exp_ovs = (spd > LIM) ? 1 : 0;
    num_veh = 2'(nv);
    snap();
    sen1 = 1'b1;
    tick();
    sen1 = 1'b0;
    check({tag, "_init_now"}, int'(init), 1);
    repeat (gap - 1) tick();
    sen2 = 1'b1;
    tick();
    sen2 = 1'b0;
    check({tag, "_cal_now"}, int'({cal, count}), 2);
    repeat ($urandom_range(1, 4)) tick();
    speed = 14'(spd);
    done  = 1'b1;
    tick();
    done  = 1'b0;
    if (exit_open) begin
      tick();
      tick();
      exit_sen = 1'b1;
      tick();
      exit_sen = 1'b0;
    end
    k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    check({tag, "_ends"}, (k < 100) ? 1 : 0, 1);
    repeat (6) tick();
    check({tag, "_n_init"},  m_init - b_init, 1);
    check({tag, "_n_count"}, m_count - b_count, gap);
    check({tag, "_n_cal"},   m_cal - b_cal, 1);
    check({tag, "_n_up"},    m_up - b_up, admit ? 1 : 0);
    check({tag, "_n_en"},    m_en - b_en, admit ? B : 0);
    check({tag, "_n_dis"},   m_dis - b_dis, 1);
    check({tag, "_n_down"},  m_down - b_down, (exit_open && nv != 0) ? 1 : 0);
    check({tag, "_updown"},  m_updown - b_updown, 0);
    check({tag, "_down_busy"}, m_down_busy - b_down_busy, 0);
    check({tag, "_ovs"},     int'(overspeed), exp_ovs);
    check({tag, "_busy"},    int'(busy), 0);
    if (admit) check({tag, "_dis_after_en"}, dis_last - en_last, 1);
    if (admit && exit_open && nv != 0)
      check({tag, "_down_at_idle"},
            (down_last - idle_first >= 0 && down_last - idle_first <= 1) ? 1 : 0, 1);
  endtask

  task automatic idle_exit(input string tag, input int nv);
    num_veh = 2'(nv);
    snap();
    exit_sen = 1'b1;
    tick();
    exit_sen = 1'b0;
    repeat (5) tick();
    check({tag, "_n_down"}, m_down - b_down, (nv != 0) ? 1 : 0);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    repeat (2) tick();
    check("rst_outs_held", int'(outs), 0);
    reset = 1'b0;
    tick();
    check("rst_outs_after", int'(outs), 0);

    run_pass("admit30", 50, 30, 0, 1'b0);
    run_pass("lim40",   10, 40, 1, 1'b0);
    run_pass("ovs41",   10, 41, 1, 1'b0);
    run_pass("full",    12, 10, 3, 1'b0);
    run_pass("exit_open", 15, 25, 2, 1'b1);
    idle_exit("exit_nv1", 1);
    idle_exit("exit_nv0", 0);

    for (int i = 0; i < 6; i++)
      run_pass($sformatf("rnd%0d", i), int'($urandom_range(3, 40)), int'($urandom_range(0, 80)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Timeout: both instances reject for speed first, then the short-timeout one times out.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    run_pass("pre_tmo", 10, 41, 1, 1'b0);
    check("pre_tmo_t_ovs", int'(t_overspeed), 1);
    num_veh = 2'd0;
    snap();
    sen1 = 1'b1;
    tick();
    sen1 = 1'b0;
    k = 0;
    while (t_busy && k < 100) begin
      tick();
      k++;
    end
    check("tmo_ends", (k < 100) ? 1 : 0, 1);
    repeat (3) tick();
    check("tmo_n_count", t_count_n - b_tcount, TMO_T);
    check("tmo_n_dis",   t_dis_n - b_tdis, 1);
    check("tmo_busy",    int'(t_busy), 0);
    check("tmo_ovs_kept", int'(t_overspeed), 1);

    // Main instance is still measuring: pend an exit, then reset.
    check("mid_busy", int'({busy, count}), 3);
    num_veh  = 2'd2;
    exit_sen = 1'b1;
    tick();
    exit_sen = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_outs", int'(outs), 0);
    snap();
    repeat (6) tick();
    check("mid_rst_no_down", m_down - b_down, 0);
    check("mid_rst_no_init", m_init - b_init, 0);
    check("mid_rst_idle",    int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
